// File: rtl/xor_hash_sched.sv
// -----------------------------------------------------------------------------
// xor_hash_sched
//
// Shares one 512-bit XOR-fold hash between NUM_REQ requesters. A requester
// streams a block as 16 beats of 32 bits, with beat 0 as the most significant
// word. The scheduler grants one requester and locks the grant for the whole
// block. It then folds the 64 bytes into an 8-bit digest. The digest is
// returned with the ID of the requester that sent the block.
//
// Configuration macro:
//   XOR_HASH_SCHED_FIXED_PRIO_EN
//     Defined   : fixed priority, the lowest index wins.
//     Undefined : round-robin, starting after the last granted requester.
//
// Ports:
//   clk         in   single clock
//   rst         in   synchronous, active-high reset
//   req_valid   in   [NUM_REQ]      per-requester beat valid
//   req_data    in   [NUM_REQ*32]   per-requester beat; requester k uses [32k+31:32k]
//   req_ready   out  [NUM_REQ]      per-requester beat accept (at most one bit high)
//   dout_valid  out                 digest valid
//   dout_ready  in                  consumer accepts the digest
//   dout_data   out  [8]            digest
//   dout_id     out  [ID_W]         requester the digest belongs to
//   busy        out                 high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module xor_hash_sched #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*32-1:0] req_data,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic [7:0]            dout_data,
    output logic [ID_W-1:0]       dout_id,
    output logic                  busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HASH = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    // XOR of all 64 bytes of the block.
    function automatic logic [7:0] xor_fold(input logic [511:0] blk);
        logic [7:0] acc;
        acc = 8'h00;
        for (int b = 0; b < 64; b++) begin
            acc = acc ^ blk[8*b +: 8];
        end
        return acc;
    endfunction

`ifdef XOR_HASH_SCHED_FIXED_PRIO_EN
    // Lowest-index valid requester wins.
    function automatic logic [ID_W-1:0] pick_grant(input logic [NUM_REQ-1:0] v);
        logic [ID_W-1:0] g;
        g = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (v[k]) begin
                g = ID_W'(k);
            end
        end
        return g;
    endfunction
`else
    // Round-robin: the first valid index above 'last' wins. If none is
    // found, the search wraps to the lowest valid index.
    function automatic logic [ID_W-1:0] pick_grant(input logic [NUM_REQ-1:0] v,
                                                   input logic [ID_W-1:0]    last);
        logic [ID_W-1:0] g_wrap;
        logic [ID_W-1:0] g_hi;
        logic            hi_found;
        g_wrap   = '0;
        g_hi     = '0;
        hi_found = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (v[k]) begin
                g_wrap = ID_W'(k);
                if (k > int'(last)) begin
                    g_hi     = ID_W'(k);
                    hi_found = 1'b1;
                end
            end
        end
        return hi_found ? g_hi : g_wrap;
    endfunction
`endif

    state_t               state_r;
    logic [ID_W-1:0]      grant_r;
    logic [3:0]           cnt_r;
    logic [511:0]         buf_r;
    logic [NUM_REQ-1:0]   req_ready_r;
    logic                 dout_valid_r;
    logic [7:0]           dout_data_r;
    logic [ID_W-1:0]      dout_id_r;
    logic                 busy_r;
`ifndef XOR_HASH_SCHED_FIXED_PRIO_EN
    logic [ID_W-1:0]      last_grant_r;
`endif

    logic [ID_W-1:0]      pick_s;
    logic [NUM_REQ-1:0]   pick_onehot_s;
    logic [31:0]          beat_s;
    logic                 beat_valid_s;
    logic [8:0]           wr_lsb_s;

    // Arbitration result and its one-hot ready pattern for the IDLE cycle.
    always_comb begin
`ifdef XOR_HASH_SCHED_FIXED_PRIO_EN
        pick_s = pick_grant(req_valid);
`else
        pick_s = pick_grant(req_valid, last_grant_r);
`endif
        pick_onehot_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_s;
    end

    // Select the granted requester's beat and valid (AND-OR mux).
    always_comb begin
        beat_s       = 32'h0000_0000;
        beat_valid_s = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            beat_s       = beat_s | (req_data[32*k +: 32] & {32{grant_r == ID_W'(k)}});
            beat_valid_s = beat_valid_s | (req_valid[k] & (grant_r == ID_W'(k)));
        end
    end

    // Beat j lands at [511-32j -: 32], so its LSB is at (15-j)*32.
    always_comb begin
        wr_lsb_s = {4'd15 - cnt_r, 5'd0};
    end

    // Main sequencer: arbitration, block load, fold and digest handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            grant_r      <= '0;
            cnt_r        <= 4'd0;
            req_ready_r  <= '0;
            dout_valid_r <= 1'b0;
            dout_data_r  <= 8'h00;
            dout_id_r    <= '0;
            busy_r       <= 1'b0;
`ifndef XOR_HASH_SCHED_FIXED_PRIO_EN
            last_grant_r <= ID_W'(NUM_REQ - 1);
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (|req_valid) begin
                        grant_r      <= pick_s;
`ifndef XOR_HASH_SCHED_FIXED_PRIO_EN
                        last_grant_r <= pick_s;
`endif
                        cnt_r        <= 4'd0;
                        req_ready_r  <= pick_onehot_s;
                        busy_r       <= 1'b1;
                        state_r      <= ST_LOAD;
                    end else begin
                        state_r      <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    // The ready bit is already high for the grant, so valid alone
                    // completes the handshake. Without valid, the FSM holds.
                    if (beat_valid_s) begin
                        buf_r[wr_lsb_s +: 32] <= beat_s;
                        cnt_r                 <= cnt_r + 4'd1;
                        if (cnt_r == 4'd15) begin
                            req_ready_r <= '0;
                            state_r     <= ST_HASH;
                        end else begin
                            state_r     <= ST_LOAD;
                        end
                    end else begin
                        state_r <= ST_LOAD;
                    end
                end
                ST_HASH: begin
                    dout_data_r  <= xor_fold(buf_r);
                    dout_id_r    <= grant_r;
                    dout_valid_r <= 1'b1;
                    state_r      <= ST_OUT;
                end
                ST_OUT: begin
                    if (dout_ready) begin
                        dout_valid_r <= 1'b0;
                        busy_r       <= 1'b0;
                        state_r      <= ST_IDLE;
                    end else begin
                        state_r      <= ST_OUT;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    req_ready_r  <= '0;
                    dout_valid_r <= 1'b0;
                    busy_r       <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_r;
    assign dout_valid = dout_valid_r;
    assign dout_data  = dout_data_r;
    assign dout_id    = dout_id_r;
    assign busy       = busy_r;

endmodule

// File: doc/xor_hash_sched.md
# xor_hash_sched

Scheduler and sequencer for the 512-bit XOR-fold hash datapath (digest = XOR of all 64 bytes of a block). Several requesters stream 512-bit blocks as 32-bit beats. The block shares one hash instance between them: it arbitrates, assembles the block in a buffer, runs the fold and returns an 8-bit digest tagged with the requester ID. It sits between the requester ports and the digest consumer.

## Interface
- `NUM_REQ`, default 2: number of requesters; legal range 2..8.
- `ID_W`, default `$clog2(NUM_REQ)` (minimum 1): width of the requester ID.
- `clk` in 1: the single clock.
- `rst` in 1: reset, synchronous and active-high.
- `req_valid` in NUM_REQ: per-requester beat valid.
- `req_data` in NUM_REQ*32: per-requester beat. Requester k uses `[32k+31:32k]`.
- `req_ready` out NUM_REQ: per-requester beat accept. At most one bit is high at a time.
- `dout_valid` out 1: digest valid.
- `dout_ready` in 1: consumer accepts the digest.
- `dout_data` out 8: digest.
- `dout_id` out ID_W: index of the requester the digest belongs to.
- `busy` out 1: high in any state other than IDLE.

## Operation
- **Block framing:** a block is exactly 16 beats; there is no last flag. Beat j (0..15) fills buffer bits `[511-32j -: 32]`, so beat 0 is the most significant word.
- **Beat acceptance:** a beat is accepted on a cycle where both `req_valid[g]` and `req_ready[g]` are high, with g the granted requester.
- **States:** IDLE, LOAD, HASH, OUT.
  - **IDLE:** if any `req_valid` bit is high, latch grant g and clear the beat counter, then go to LOAD. Otherwise stay in IDLE.
  - **LOAD:** `req_ready[g]` = 1. Each accepted beat writes the buffer and increments the 4-bit counter. Accepting beat 15 moves to HASH. While `req_valid[g]` = 0 the FSM holds, with counter and buffer unchanged. The grant is locked until the block completes; other requesters see `req_ready` = 0.
  - **HASH:** register the fold of the buffer into `dout_data` and g into `dout_id`. Go to OUT.
  - **OUT:** `dout_valid` = 1. `dout_data` and `dout_id` stay stable until `dout_ready` = 1. On handshake go to IDLE.
- **Arbitration (default, round-robin):** search starts at `last_grant+1` mod NUM_REQ. `last_grant` updates when the grant is latched. After reset `last_grant` = NUM_REQ-1, so requester 0 wins first.
- **Buffer:** not cleared between blocks. All 16 positions are overwritten before every HASH.
- **Reset values:** `req_ready` = 0, `dout_valid` = 0, `dout_data` = 0x00, `dout_id` = 0, `busy` = 0, state IDLE, counter 0, `last_grant` = NUM_REQ-1.
- **Reset mid-operation:** any partial block is discarded and any pending digest is dropped. The requester must restart from beat 0.

## Timing
- Grant latched at cycle t (IDLE, some `req_valid` high). `req_ready[g]` is high from t+1.
- With no stalls, beats are accepted at t+1..t+16, HASH is at t+17, and `dout_valid` rises at t+18.
- Each stall cycle (`req_valid[g]` low in LOAD) adds exactly one cycle.
- If `dout_ready` is already high at t+18, OUT lasts one cycle and IDLE is at t+19. Peak throughput is one block per 19 cycles.
- Backpressure: each cycle `dout_ready` is low in OUT adds one cycle. No `req_ready` is asserted during HASH or OUT.
- A `req_valid` change in IDLE is sampled only on the arbitration cycle. Grant decisions depend only on registered state and the current `req_valid`.

## Configuration
- Macro `XOR_HASH_SCHED_FIXED_PRIO_EN`.
- Defined: fixed priority, lowest index wins. `last_grant` is not used.
- Undefined: round-robin as described in Operation.
- All other behaviour and timing are identical in both builds.

## Test plan
- **Single block, digest 0xA5:** requester 0 sends beat 0 = 0xA5000000 and beats 1..15 = 0. Expect `dout_data` = 0xA5, `dout_id` = 0, `dout_valid` rising exactly 18 cycles after the grant cycle.
- **Odd byte count, digest 0xF0:** beats 0..14 = 0x000000FF and beat 15 = 0x0000000F. Expect `dout_data` = 0xF0.
- **Round-robin fairness:** requesters 0 and 1 both keep `req_valid` high for 4 blocks. Expect `dout_id` sequence 0,1,0,1 and `req_ready` never high for both requesters in the same cycle. With `XOR_HASH_SCHED_FIXED_PRIO_EN` defined, expect 0,0,0,0.
- **Input stall:** drop `req_valid[g]` for 3 cycles after beat 7. Expect the counter to hold, the digest to be unchanged, and `dout_valid` to rise 3 cycles later than the no-stall case.
- **Output backpressure:** hold `dout_ready` low for 5 cycles in OUT. Expect `dout_valid`, `dout_data` and `dout_id` stable and all `req_ready` = 0 for those 5 cycles. Expect IDLE on the cycle after the handshake.
- **Reset mid-block:** assert `rst` for 1 cycle after beat 6. Expect all outputs at their reset values on the next cycle. A fresh 16-beat block then yields the correct digest, with no leftover effect from the aborted beats.
